// File: rtl/spram32_bridge_if.sv
// Bus bundle for spram32_bridge: the 32-bit word request/response port
// toward the CPU/DMA master plus the 16-bit port toward the SPRAM wrapper.
// The slave view belongs to the bridge. The master view is the environment
// around it: it drives requests and returns SPRAM read data.
interface spram32_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic [12:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [13:0] spram_addr;
    logic [15:0] spram_data_in;
    logic [3:0]  spram_wmask;
    logic        spram_wenable;
    logic [15:0] spram_data_out;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_wstrb, spram_data_out,
        output req_ready, rsp_valid, rsp_rdata,
        output spram_addr, spram_data_in, spram_wmask, spram_wenable
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_wstrb, spram_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
        input  spram_addr, spram_data_in, spram_wmask, spram_wenable
    );
endinterface

// File: rtl/spram32_bridge.sv
// spram32_bridge: presents 8K x 32 memory with byte-enable writes on top of
// a single 16K x 16 iCE40 SPRAM. Each word access becomes two 16-bit
// accesses, low half first. One transaction is in flight at a time, and a
// new one can be accepted in the cycle the previous one completes.
// Optional feature: define SPRAM_BRIDGE_REGOUT_EN to add one register
// stage on rsp_valid/rsp_rdata, which raises the latency from 3 to 4.
module spram32_bridge (
    input  logic            clock,
    input  logic            reset,
    spram32_bridge_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;

    logic [12:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        isWrite_q;
    logic [31:0] rdata_q;

    logic [13:0] spramAddr_q, spramAddr_d;
    logic [15:0] spramData_q, spramData_d;
    logic [3:0]  spramWmask_q, spramWmask_d;
    logic        spramWenable_q, spramWenable_d;

    logic        reqReady;
    logic        accept;
    logic        rspFire;
    logic [31:0] rdataNow;

    assign reqReady = (state_q == IDLE) || (state_q == FIN);
    assign accept   = bus.req_valid && reqReady;
    assign rspFire  = (state_q == FIN);

    // The upper read half arrives during FIN, so it is forwarded straight from the SPRAM to build the full word.
    assign rdataNow = (rspFire && !isWrite_q) ? {bus.spram_data_out, rdata_q[15:0]} : rdata_q;

    // Next state and the SPRAM drive values that take effect on entry to LO or HI
    always_comb begin
        state_d        = state_q;
        spramAddr_d    = spramAddr_q;
        spramData_d    = spramData_q;
        spramWmask_d   = 4'b0000;
        spramWenable_d = 1'b0;
        case (state_q)
            IDLE, FIN: begin
                if (accept) begin
                    state_d        = LO;
                    spramAddr_d    = {bus.req_addr, 1'b0};
                    spramData_d    = bus.req_wdata[15:0];
                    spramWmask_d   = {bus.req_wstrb[1], bus.req_wstrb[1],
                                      bus.req_wstrb[0], bus.req_wstrb[0]};
                    spramWenable_d = |bus.req_wstrb[1:0];
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                state_d        = HI;
                spramAddr_d    = {addr_q, 1'b1};
                spramData_d    = wdata_q[31:16];
                spramWmask_d   = {wstrb_q[3], wstrb_q[3], wstrb_q[2], wstrb_q[2]};
                spramWenable_d = |wstrb_q[3:2];
            end
            HI: begin
                state_d = FIN;
            end
        endcase
    end

    // State register and registered SPRAM drive; reset drops wenable without waiting for a clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            spramAddr_q    <= '0;
            spramData_q    <= '0;
            spramWmask_q   <= '0;
            spramWenable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            spramAddr_q    <= spramAddr_d;
            spramData_q    <= spramData_d;
            spramWmask_q   <= spramWmask_d;
            spramWenable_q <= spramWenable_d;
        end
    end

    // Hold the accepted request so the high half can be issued after the low half
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            isWrite_q <= 1'b0;
        end else if (accept) begin
            addr_q    <= bus.req_addr;
            wdata_q   <= bus.req_wdata;
            wstrb_q   <= bus.req_wstrb;
            isWrite_q <= |bus.req_wstrb;
        end
    end

    // Collect read halves as they come back one cycle after their address; writes leave the data alone
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (!isWrite_q) begin
            if (state_q == HI) begin
                rdata_q[15:0] <= bus.spram_data_out;
            end else if (state_q == FIN) begin
                rdata_q[31:16] <= bus.spram_data_out;
            end
        end
    end

`ifdef SPRAM_BRIDGE_REGOUT_EN
    logic        rspValid_q;
    logic [31:0] rspRdata_q;

    // Extra output stage on the response; the state machine timing is unchanged
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            rspValid_q <= rspFire;
            rspRdata_q <= rdataNow;
        end
    end

    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
`else
    assign bus.rsp_valid = rspFire;
    assign bus.rsp_rdata = rdataNow;
`endif

    assign bus.req_ready     = reqReady;
    assign bus.spram_addr    = spramAddr_q;
    assign bus.spram_data_in = spramData_q;
    assign bus.spram_wmask   = spramWmask_q;
    assign bus.spram_wenable = spramWenable_q;

endmodule

// File: tb/tb_spram32_bridge.sv
// Testbench for spram32_bridge. It models the 16K x 16 SPRAM with a
// nibble-masked synchronous memory and keeps a 32-bit word image of the
// memory as the reference for the expected read data.
module tb_spram32_bridge;

`ifdef SPRAM_BRIDGE_REGOUT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clock = 1'b0;
    logic reset;

    spram32_bridge_if bus();

    spram32_bridge dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [13:0] loAddr;
        logic [15:0] loData;
        logic [3:0]  loMask;
        logic        loWe;
        logic [13:0] hiAddr;
        logic [15:0] hiData;
        logic [3:0]  hiMask;
        logic        hiWe;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vecs [8];
    logic [15:0] spramMem [16384];
    logic [31:0] refMem [8192];

    int          checkCount = 0;
    int          passCount  = 0;

    logic [13:0] loAddr, hiAddr;
    logic [15:0] loData, hiData;
    logic [3:0]  loMask, hiMask;
    logic        loWe, hiWe;
    int          gotLat;
    logic [31:0] gotRdata;
    logic [31:0] lastRead;

    // SPRAM stand-in: synchronous read, nibble-masked write on the rising edge
    always @(posedge clock) begin : spramModel
        logic [15:0] merged;
        bus.spram_data_out <= spramMem[bus.spram_addr];
        if (bus.spram_wenable) begin
            merged = spramMem[bus.spram_addr];
            for (int i = 0; i < 4; i++) begin
                if (bus.spram_wmask[i]) merged[4*i +: 4] = bus.spram_data_in[4*i +: 4];
            end
            spramMem[bus.spram_addr] <= merged;
        end
    end

    // Compare one value and keep the running tallies
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one transaction from a falling edge: snapshot the LO and HI drive, measure latency, update the word image
    task automatic applyStimulus(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        bit done;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_wstrb = s;
        checkOutput("req_ready at request", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clock);
        gotLat   = 0;
        gotRdata = '0;
        done     = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (!done) begin
                @(negedge clock);
                if (n == 1) begin
                    bus.req_valid = 1'b0;
                    loAddr = bus.spram_addr;
                    loData = bus.spram_data_in;
                    loMask = bus.spram_wmask;
                    loWe   = bus.spram_wenable;
                end
                if (n == 2) begin
                    hiAddr = bus.spram_addr;
                    hiData = bus.spram_data_in;
                    hiMask = bus.spram_wmask;
                    hiWe   = bus.spram_wenable;
                end
                if (bus.rsp_valid) begin
                    gotLat   = n;
                    gotRdata = bus.rsp_rdata;
                    done     = 1'b1;
                end
            end
        end
        for (int b = 0; b < 4; b++) begin
            if (s[b]) refMem[a][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    initial begin : main
        logic [12:0] b2bAddr [3];
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] expData;
        logic        expValid;

        for (int i = 0; i < 16384; i++) spramMem[i] = 16'h0000;
        for (int i = 0; i < 8192; i++) refMem[i] = 32'h0;

        // Known write/readback patterns, including partial strobes and the top address
        vecs[0] = '{13'h0005, 32'hDEADBEEF, 4'hF, 14'h000A, 16'hBEEF, 4'hF, 1'b1, 14'h000B, 16'hDEAD, 4'hF, 1'b1, 32'h00000000};
        vecs[1] = '{13'h0005, 32'h00000000, 4'h0, 14'h000A, 16'h0000, 4'h0, 1'b0, 14'h000B, 16'h0000, 4'h0, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{13'h0005, 32'h11223344, 4'h4, 14'h000A, 16'h3344, 4'h0, 1'b0, 14'h000B, 16'h1122, 4'h3, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{13'h0005, 32'h00000000, 4'h0, 14'h000A, 16'h0000, 4'h0, 1'b0, 14'h000B, 16'h0000, 4'h0, 1'b0, 32'hDE22BEEF};
        vecs[4] = '{13'h1FFF, 32'hA5A55A5A, 4'hF, 14'h3FFE, 16'h5A5A, 4'hF, 1'b1, 14'h3FFF, 16'hA5A5, 4'hF, 1'b1, 32'hDE22BEEF};
        vecs[5] = '{13'h1FFF, 32'h00000000, 4'h0, 14'h3FFE, 16'h0000, 4'h0, 1'b0, 14'h3FFF, 16'h0000, 4'h0, 1'b0, 32'hA5A55A5A};
        vecs[6] = '{13'h0100, 32'h12345678, 4'h8, 14'h0200, 16'h5678, 4'h0, 1'b0, 14'h0201, 16'h1234, 4'hC, 1'b1, 32'hA5A55A5A};
        vecs[7] = '{13'h0100, 32'h00000000, 4'h0, 14'h0200, 16'h0000, 4'h0, 1'b0, 14'h0201, 16'h0000, 4'h0, 1'b0, 32'h12000000};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Everything must come out of reset idle and zeroed
        checkOutput("reset req_ready",     {31'b0, bus.req_ready},     32'd1);
        checkOutput("reset rsp_valid",     {31'b0, bus.rsp_valid},     32'd0);
        checkOutput("reset rsp_rdata",     bus.rsp_rdata,              32'd0);
        checkOutput("reset spram_addr",    {18'b0, bus.spram_addr},    32'd0);
        checkOutput("reset spram_data_in", {16'b0, bus.spram_data_in}, 32'd0);
        checkOutput("reset spram_wmask",   {28'b0, bus.spram_wmask},   32'd0);
        checkOutput("reset spram_wenable", {31'b0, bus.spram_wenable}, 32'd0);

        // Table of fixed vectors, each issued straight after the previous response
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            checkOutput($sformatf("vec%0d lo addr", i), {18'b0, loAddr}, {18'b0, vecs[i].loAddr});
            checkOutput($sformatf("vec%0d lo data", i), {16'b0, loData}, {16'b0, vecs[i].loData});
            checkOutput($sformatf("vec%0d lo mask", i), {28'b0, loMask}, {28'b0, vecs[i].loMask});
            checkOutput($sformatf("vec%0d lo we", i),   {31'b0, loWe},   {31'b0, vecs[i].loWe});
            checkOutput($sformatf("vec%0d hi addr", i), {18'b0, hiAddr}, {18'b0, vecs[i].hiAddr});
            checkOutput($sformatf("vec%0d hi data", i), {16'b0, hiData}, {16'b0, vecs[i].hiData});
            checkOutput($sformatf("vec%0d hi mask", i), {28'b0, hiMask}, {28'b0, vecs[i].hiMask});
            checkOutput($sformatf("vec%0d hi we", i),   {31'b0, hiWe},   {31'b0, vecs[i].hiWe});
            checkOutput($sformatf("vec%0d latency", i), gotLat, LAT);
            checkOutput($sformatf("vec%0d rdata", i),   gotRdata, vecs[i].rdata);
        end
        @(negedge clock);

        // Three reads with req_valid held high; stray writes are offered while the bridge is busy
        b2bAddr[0] = 13'h0005;
        b2bAddr[1] = 13'h1FFF;
        b2bAddr[2] = 13'h0100;
        for (int c = 0; c <= 11; c++) begin
            if (c <= 9) begin
                checkOutput($sformatf("b2b ready c%0d", c), {31'b0, bus.req_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
            end
            expValid = (c >= LAT) && ((c - LAT) % 3 == 0) && ((c - LAT) / 3 < 3);
            checkOutput($sformatf("b2b rsp_valid c%0d", c), {31'b0, bus.rsp_valid}, {31'b0, expValid});
            if (expValid) begin
                checkOutput($sformatf("b2b rdata c%0d", c), bus.rsp_rdata, refMem[b2bAddr[(c - LAT) / 3]]);
            end
            if (c <= 6 && c % 3 == 0) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = b2bAddr[c / 3];
                bus.req_wdata = 32'h0;
                bus.req_wstrb = 4'h0;
            end else if (c <= 6) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 13'($urandom);
                bus.req_wdata = $urandom;
                bus.req_wstrb = 4'hF;
            end else begin
                bus.req_valid = 1'b0;
                bus.req_wstrb = 4'h0;
            end
            @(negedge clock);
        end

        // Reset lands during HI of a write: only the low half reaches memory
        applyStimulus(13'h0200, 32'hCAFEF00D, 4'hF);
        checkOutput("pre-reset write latency", gotLat, LAT);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_addr  = 13'h0200;
        bus.req_wdata = 32'h0BAD0BAD;
        bus.req_wstrb = 4'hF;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        @(negedge clock);
        checkOutput("HI wenable before reset", {31'b0, bus.spram_wenable}, 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("async wenable drop", {31'b0, bus.spram_wenable}, 32'd0);
        checkOutput("rsp_valid in reset", {31'b0, bus.rsp_valid}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("req_ready after reset", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("rsp_rdata after reset", bus.rsp_rdata, 32'd0);
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("no rsp after abort c%0d", c), {31'b0, bus.rsp_valid}, 32'd0);
            @(negedge clock);
        end
        refMem[13'h0200] = 32'hCAFE0BAD;
        applyStimulus(13'h0200, 32'h0, 4'h0);
        checkOutput("abort readback latency", gotLat, LAT);
        checkOutput("abort readback rdata", gotRdata, 32'hCAFE0BAD);
        lastRead = 32'hCAFE0BAD;

        // Random mix of reads and byte-masked writes over a small address pool at both ends of memory
        for (int k = 0; k < 40; k++) begin
            a = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 7)) : 13'(13'h1FF8 + 13'($urandom_range(0, 7)));
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            expData = refMem[a];
            applyStimulus(a, d, s);
            checkOutput($sformatf("rand%0d latency", k), gotLat, LAT);
            if (s == 4'h0) begin
                checkOutput($sformatf("rand%0d read a=%0h", k, a), gotRdata, expData);
                lastRead = expData;
            end else begin
                checkOutput($sformatf("rand%0d write hold", k), gotRdata, lastRead);
            end
        end

        @(negedge clock);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
